// File: rtl/lsu_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// The slave modport is the LSU; the master modport is the core plus the memory.
interface lsu_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_sign;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_MemWrite;
  logic        o_MemRead;
  logic [31:0] o_address;
  logic [31:0] o_data;
  logic [31:0] i_data;

  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_sign, i_req_addr, i_req_wdata, i_data,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
           o_MemWrite, o_MemRead, o_address, o_data
  );

  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_sign, i_req_addr, i_req_wdata, i_data,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
           o_MemWrite, o_MemRead, o_address, o_data
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store unit in front of a word-organised data memory.
// Sub-word stores use a read-modify-write; all outputs decode from flops only.
module lsu_ctrl #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  lsu_if.slave  bus
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4,
    ERR    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_bad_s;

  function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad || ({2'b00, addr[31:2]} >= MEM_WORDS_W);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic sign, input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   res = sign ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
      2'b01:   res = sign ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      2'b10:   res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Lanes are little-endian: byte n lives in bits 8n+7:8n.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      2'b00: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        data = {24'd0, wdata[7:0]} << {off, 3'b000};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {off[1], 4'b0000};
        data = {16'd0, wdata[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
    endcase
    return (word & ~mask) | (data & mask);
  endfunction

  assign req_bad_s = req_bad(bus.i_req_size, bus.i_req_addr);

  // State and latched request registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, request capture, load extraction and store merge.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          we_d    = bus.i_req_we;
          size_d  = bus.i_req_size;
          sign_d  = bus.i_req_sign;
          addr_d  = bus.i_req_addr;
          wdata_d = bus.i_req_wdata;
          rdata_d = 32'd0;
          if (req_bad_s) begin
            state_d = ERR;
          end else if (!bus.i_req_we) begin
            state_d = RD;
          end else if (bus.i_req_size == 2'b10) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        rdata_d = load_extract(bus.i_data, size_q, sign_q, addr_q[1:0]);
        state_d = RESP;
      end
      RMW_RD: begin
        wdata_d = store_merge(bus.i_data, wdata_q, size_q, addr_q[1:0]);
        state_d = WR;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_req_ready  = (state_q == IDLE);
  assign bus.o_resp_valid = (state_q == RESP) || (state_q == ERR);
  assign bus.o_resp_err   = (state_q == ERR);
  assign bus.o_resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
  assign bus.o_MemRead    = (state_q == RD) || (state_q == RMW_RD);
  assign bus.o_MemWrite   = (state_q == WR);
  assign bus.o_address    = {2'b00, addr_q[31:2]};
  assign bus.o_data       = (state_q == WR) ? wdata_q : 32'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural 32-word memory and a response scoreboard.
module tb_lsu_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
    int          rd0;
    int          wr0;
    int          nrd;
    int          nwr;
  } exp_t;

  logic        i_clk;
  logic        rst_n;
  int          tests;
  int          fails;
  int          cyc;
  int          rd_cnt;
  int          wr_cnt;
  int          acc_cnt;
  int          resp_cnt;
  int          pushed;
  exp_t        sb_q[$];
  logic [31:0] mem [0:31];

  lsu_if bus();

  lsu_ctrl #(.MEM_WORDS(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  assign bus.i_data = bus.o_MemRead ? mem[bus.o_address[4:0]] : 32'd0;

  always @(posedge i_clk) begin
    if (bus.o_MemWrite) mem[bus.o_address[4:0]] <= bus.o_data;
  end

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.i_req_valid && bus.o_req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: memory-strobe bookkeeping and scoreboard pop.
  always @(negedge i_clk) begin
    if (rst_n) begin
      if (bus.o_MemRead && bus.o_MemWrite) chk("rd_wr_overlap", 32'd1, 32'd0);
      if (bus.o_MemRead) rd_cnt++;
      if (bus.o_MemWrite) wr_cnt++;
      if (bus.o_resp_valid) begin
        resp_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("resp_rdata", bus.o_resp_rdata, e.rdata);
          chk("resp_err", {31'd0, bus.o_resp_err}, {31'd0, e.err});
          chk("resp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
          chk("mem_reads", 32'(rd_cnt - e.rd0), 32'(e.nrd));
          chk("mem_writes", 32'(wr_cnt - e.wr0), 32'(e.nwr));
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input logic keep);
    int n;
    exp_t e;
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = we;
    bus.i_req_size  = size;
    bus.i_req_sign  = sign;
    bus.i_req_addr  = addr;
    bus.i_req_wdata = wdata;
    n = 0;
    while (bus.o_req_ready !== 1'b1 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'd1, 32'd0);
      bus.i_req_valid = 1'b0;
      return;
    end
    e.rdata   = exp_rdata;
    e.err     = exp_err;
    e.acc_cyc = cyc;
    e.lat     = exp_err ? 1 : ((we && size != 2'b10) ? 3 : 2);
    e.rd0     = rd_cnt;
    e.wr0     = wr_cnt;
    e.nrd     = (!exp_err && (!we || size != 2'b10)) ? 1 : 0;
    e.nwr     = (!exp_err && we) ? 1 : 0;
    sb_q.push_back(e);
    pushed++;
    @(posedge i_clk);
    @(negedge i_clk);
    if (!exp_err) chk("o_address", bus.o_address, {2'b00, addr[31:2]});
    if (!keep) bus.i_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    @(negedge i_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    tests = 0; fails = 0; cyc = 0; rd_cnt = 0; wr_cnt = 0;
    acc_cnt = 0; resp_cnt = 0; pushed = 0;
    bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_size = 2'b00;
    bus.i_req_sign = 1'b0; bus.i_req_addr = 32'd0; bus.i_req_wdata = 32'd0;
    rst_n = 1'b0;
    #12;
    chk("rst_ready", {31'd0, bus.o_req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.o_resp_valid}, 32'd0);
    chk("rst_outputs", {bus.o_resp_err, bus.o_MemRead, bus.o_MemWrite}, 32'd0);
    chk("rst_addr_data", bus.o_address | bus.o_data | bus.o_resp_rdata, 32'd0);
    @(negedge i_clk);
    rst_n = 1'b1;
    @(negedge i_clk);

    // word store/load round trip
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    drain();
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    drain();
    // byte store via read-modify-write, then sub-word loads
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0055, 32'd0, 1'b0, 1'b0);
    drain();
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDE55_BEEF, 1'b0, 1'b0);
    drain();
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 32'h0000_0055, 1'b0, 1'b0);
    drain();
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 32'hFFFF_DE55, 1'b0, 1'b0);
    drain();
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'h0000_DE55, 1'b0, 1'b0);
    drain();
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'hFFFF_FFDE, 1'b0, 1'b0);
    drain();
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'h0000_00EF, 1'b0, 1'b0);
    drain();
    // halfword store to upper lane of word 5, and last word of memory
    do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h1122_3344, 32'd0, 1'b0, 1'b0);
    drain();
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_A5A5, 32'd0, 1'b0, 1'b0);
    drain();
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'hA5A5_3344, 1'b0, 1'b0);
    drain();
    do_req(1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    drain();
    do_req(1'b0, 2'b10, 1'b0, 32'h7C, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0);
    drain();

    // error cases: misaligned, illegal size, out of range
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 32'd0, 1'b1, 1'b0);
    drain();
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 32'd0, 1'b1, 1'b0);
    drain();
    do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'd0, 32'd0, 1'b1, 1'b0);
    drain();
    do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 32'd0, 1'b1, 1'b0);
    drain();
    do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    drain();

    // back-to-back with valid held high
    do_req(1'b1, 2'b00, 1'b0, 32'h18, 32'h0000_0077, 32'd0, 1'b0, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDE55_BEEF, 1'b0, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'd0, 32'd0, 1'b1, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 32'h1C, 32'h0BAD_F00D, 32'd0, 1'b0, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h1C, 32'd0, 32'h0BAD_F00D, 1'b0, 1'b0);
    drain();
    chk("accept_count", 32'(acc_cnt), 32'(pushed));
    chk("resp_count", 32'(resp_cnt), 32'(pushed));

    // reset while in RMW_RD must abandon the store
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_size = 2'b00;
    bus.i_req_sign = 1'b0; bus.i_req_addr = 32'h12; bus.i_req_wdata = 32'h0000_00AA;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    chk("rmw_rd_active", {31'd0, bus.o_MemRead}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", {31'd0, bus.o_req_ready}, 32'd1);
    chk("rst_mid_strobes", {bus.o_resp_valid, bus.o_resp_err, bus.o_MemRead, bus.o_MemWrite}, 32'd0);
    chk("rst_mid_addr_data", bus.o_address | bus.o_data | bus.o_resp_rdata, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    rst_n = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_mem_unchanged", mem[4], 32'hDE55_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDE55_BEEF, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: MEM_WORDS, 32, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port: i_clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: i_req_valid  input  1  core presents an access request.
REQ-005 SHALL have port: o_req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port: i_req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: i_req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port: i_req_sign  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port: i_req_addr  input  32  byte address.
REQ-010 SHALL have port: i_req_wdata  input  32  store data; sub-word data right-justified.
REQ-011 SHALL have port: o_resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: o_resp_rdata  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port: o_resp_err  output  1  misaligned, illegal-size or out-of-range access.
REQ-014 SHALL have port: o_MemWrite  output  1  data-memory write enable.
REQ-015 SHALL have port: o_MemRead  output  1  data-memory read enable.
REQ-016 SHALL have port: o_address  output  32  word index {2'b00, addr[31:2]}.
REQ-017 SHALL have port: o_data  output  32  data-memory write data.
REQ-018 SHALL have port: i_data  input  32  data-memory read data; combinational from o_address, 0 when o_MemRead=0.

Function
REQ-019 SHALL implement FSM states IDLE, RD, RMW_RD, WR, RESP, ERR.
REQ-020 SHALL assert o_req_ready only in IDLE; accept a request when i_req_valid and o_req_ready are both 1, latching all request fields.
REQ-021 SHALL go from IDLE to ERR on accept if: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; or addr[31:2] >= MEM_WORDS.
REQ-022 SHALL otherwise go IDLE->RD for a load, IDLE->WR for a word store, and IDLE->RMW_RD for a byte or halfword store.
REQ-023 SHALL drive o_MemRead=1 only in RD and RMW_RD, and o_MemWrite=1 only in WR; never both in one cycle.
REQ-024 SHALL in RD capture i_data, select the lane (byte n = bits 8n+7:8n, little-endian), zero- or sign-extend per i_req_sign, then go to RESP.
REQ-025 SHALL in RMW_RD capture i_data, merge store data into the addressed byte or halfword lane, then go to WR.
REQ-026 SHALL in WR drive o_data with the full word (word store) or merged word (sub-word store), then go to RESP.
REQ-027 SHALL in RESP assert o_resp_valid=1 with o_resp_err=0 for exactly one cycle, then return to IDLE.
REQ-028 SHALL in ERR assert o_resp_valid=1, o_resp_err=1 and o_resp_rdata=0 for one cycle, perform no memory access, then return to IDLE.
REQ-029 SHALL meet these accept-to-o_resp_valid latencies: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-030 SHALL hold o_address stable from accept until return to IDLE, and drive o_data=0 outside WR.
REQ-031 SHALL ignore i_req_valid in every state except IDLE; there is no response backpressure.

Reset
REQ-032 SHALL on i_rst_n=0, immediately and asynchronously, enter IDLE and drive o_req_ready=1 and all other outputs to 0, discarding any in-flight access without a write.
REQ-033 SHALL leave memory unmodified when reset asserts during RMW_RD.

Verification
REQ-034 SHALL pass: word store addr 0x10, data 0xDEADBEEF, then word load addr 0x10 -> o_address=4, o_MemWrite pulse in WR, load rdata 0xDEADBEEF two cycles after accept.
REQ-035 SHALL pass: memory word 4 = 0xDEADBEEF, byte store 0x55 to addr 0x12 -> word becomes 0xDE55BEEF; a signed byte load of addr 0x12 then returns 0x00000055.
REQ-036 SHALL pass: signed halfword load addr 0x12 of 0xDE55BEEF -> 0xFFFFDE55; unsigned -> 0x0000DE55.
REQ-037 SHALL pass: word load addr 0x13, halfword load addr 0x11, size 11, and word load addr 0x80 (MEM_WORDS=32) -> each gives o_resp_err=1 one cycle after accept, with no o_MemRead/o_MemWrite.
REQ-038 SHALL pass: reset asserted while in RMW_RD -> outputs clear at once, the target word is unchanged, and o_req_ready=1.
REQ-039 SHALL pass: i_req_valid held high back-to-back -> a new request is accepted only on cycles with o_req_ready=1, and each accepted request produces exactly one response.
